// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader and run monitor for the pipelined DLX core.
//   A byte stream carries an 8-byte big-endian header (word count N, PC limit)
//   followed by N big-endian 32-bit program words. Each word is written into
//   instruction memory at consecutive word addresses from BASE_ADDR while the
//   CPU is held. The CPU is then released and held again when its fetch PC
//   reaches the limit or the run-cycle budget expires.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   byte_in, byte_valid   stream byte and its valid
//   byte_ready            loader accepts a byte this cycle
//   mem_we/addr/wdata     instruction-memory write port (one pulse per word)
//   cpu_hold              1 = CPU frozen
//   cpu_pc                CPU fetch-stage PC
//   running, done         CPU executing / run finished (sticky)
//   timeout               run ended by cycle budget (sticky)
//   run_cycles            cycles spent in RUN (saturating)
// ----------------------------------------------------------------------------
module imem_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
  parameter int          MAX_CYCLES = 5000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  input  logic [31:0]      cpu_pc,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] run_cycles
);

  localparam logic [2:0] S_HDR_CNT = 3'd0;
  localparam logic [2:0] S_HDR_LIM = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [2:0]       state_q,      state_d;
  logic [1:0]       byte_idx_q,   byte_idx_d;
  logic [31:0]      sh_q,         sh_d;
  logic [CNT_W-1:0] word_cnt_q,   word_cnt_d;
  logic [CNT_W-1:0] word_idx_q,   word_idx_d;
  logic [31:0]      pc_lim_q,     pc_lim_d;
  logic             byte_ready_q, byte_ready_d;
  logic             mem_we_q,     mem_we_d;
  logic [31:0]      mem_addr_q,   mem_addr_d;
  logic [31:0]      mem_wdata_q,  mem_wdata_d;
  logic             cpu_hold_q,   cpu_hold_d;
  logic             running_q,    running_d;
  logic             done_q,       done_d;
  logic             timeout_q,    timeout_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;

  logic        xfer;
  logic        word_end;
  logic [31:0] sh_next;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    sh_d         = sh_q;
    word_cnt_d   = word_cnt_q;
    word_idx_d   = word_idx_q;
    pc_lim_d     = pc_lim_q;
    byte_ready_d = byte_ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    running_d    = running_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    run_cycles_d = run_cycles_q;

    // byte_ready is only high in the header/LOAD states, so xfer is
    // implicitly zero in WRITE, RUN and HALT.
    xfer     = byte_valid & byte_ready_q;
    sh_next  = {sh_q[23:0], byte_in};
    word_end = xfer && (byte_idx_q == 2'd3);

    if (xfer) begin
      sh_d       = sh_next;
      byte_idx_d = byte_idx_q + 2'd1;
    end

    case (state_q)
      S_HDR_CNT: begin
        if (word_end) begin
          word_cnt_d = sh_next[CNT_W-1:0];
          state_d    = S_HDR_LIM;
        end
      end
      S_HDR_LIM: begin
        if (word_end) begin
          pc_lim_d = sh_next;
          if (word_cnt_q == '0) begin
            state_d      = S_RUN;
            byte_ready_d = 1'b0;
            cpu_hold_d   = 1'b0;
            running_d    = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (word_end) begin
          state_d      = S_WRITE;
          byte_ready_d = 1'b0;
          mem_we_d     = 1'b1;
          mem_wdata_d  = sh_next;
          mem_addr_d   = BASE_ADDR + (32'(word_idx_q) << 2);
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + CNT_W'(1);
        if ((word_idx_q + CNT_W'(1)) == word_cnt_q) begin
          state_d    = S_RUN;
          cpu_hold_d = 1'b0;
          running_d  = 1'b1;
        end else begin
          state_d      = S_LOAD;
          byte_ready_d = 1'b1;
        end
      end
      S_RUN: begin
        run_cycles_d = sat_inc(run_cycles_q);
        // PC limit has priority over the budget when both hit together.
        if (cpu_pc >= pc_lim_q) begin
          state_d    = S_HALT;
          cpu_hold_d = 1'b1;
          running_d  = 1'b0;
          done_d     = 1'b1;
        end else if (run_cycles_q == LAST_CYC) begin
          state_d    = S_HALT;
          cpu_hold_d = 1'b1;
          running_d  = 1'b0;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
        end
      end
      S_HALT: begin
      end
      default: begin
        state_d = S_HDR_CNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR_CNT;
      byte_idx_q   <= 2'd0;
      sh_q         <= 32'd0;
      word_cnt_q   <= '0;
      word_idx_q   <= '0;
      pc_lim_q     <= 32'd0;
      byte_ready_q <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE_ADDR;
      mem_wdata_q  <= 32'd0;
      cpu_hold_q   <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      sh_q         <= sh_d;
      word_cnt_q   <= word_cnt_d;
      word_idx_q   <= word_idx_d;
      pc_lim_q     <= pc_lim_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader (MAX_CYCLES = 10): basic load, stop on PC
//   limit, gapped stream, zero-length program, timeout, async reset mid-load.
// ----------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] W0   = 32'h2001_0005;
  localparam logic [31:0] W1   = 32'h8C22_0000;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic [31:0] cpu_pc;
  logic        running;
  logic        done;
  logic        timeout;
  logic [15:0] run_cycles;

  int n_cmp = 0;
  int n_err = 0;

  // write log, filled by the monitor
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic        wr_rdy  [64];
  int          wr_n = 0;

  imem_loader #(
    .BASE_ADDR (BASE),
    .MAX_CYCLES(10),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .cpu_pc    (cpu_pc),
    .running   (running),
    .done      (done),
    .timeout   (timeout),
    .run_cycles(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mem_we && wr_n < 64) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_rdy[wr_n]  = byte_ready;
      wr_n          = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic put_byte(input logic [7:0] b, input bit gapped);
    int guard;
    logic acc;
    if (gapped) begin
      for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    guard      = 0;
    forever begin
      acc = byte_ready;
      @(negedge clk);
      if (acc) break;
      guard++;
      if (guard > 40) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gapped);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      put_byte(t[31:24], gapped);
      t = t << 8;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Header N=2, lim=0x00400008, then W0/W1; returns in RUN cycle 1.
  task automatic load_prog(input bit gapped, input string pfx);
    int s;
    s = wr_n;
    send_word(32'd2, gapped);
    send_word(32'h0040_0008, gapped);
    send_word(W0, gapped);
    check({pfx, "_we_w0"}, 32'(mem_we), 32'd1);
    check({pfx, "_rdy_w0"}, 32'(byte_ready), 32'd0);
    send_word(W1, gapped);
    byte_valid = 1'b0;
    check({pfx, "_we_w1"}, 32'(mem_we), 32'd1);
    check({pfx, "_hold_in_write"}, 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check({pfx, "_hold_released"}, 32'(cpu_hold), 32'd0);
    check({pfx, "_running"}, 32'(running), 32'd1);
    check({pfx, "_we_after"}, 32'(mem_we), 32'd0);
    check({pfx, "_nwrites"}, 32'(wr_n - s), 32'd2);
    if (wr_n - s == 2) begin
      check({pfx, "_addr0"}, wr_addr[s], BASE);
      check({pfx, "_data0"}, wr_data[s], W0);
      check({pfx, "_addr1"}, wr_addr[s+1], BASE + 32'd4);
      check({pfx, "_data1"}, wr_data[s+1], W1);
      check({pfx, "_rdy_wr0"}, 32'(wr_rdy[s]), 32'd0);
      check({pfx, "_rdy_wr1"}, 32'(wr_rdy[s+1]), 32'd0);
    end
  endtask

  initial begin
    int s;
    int guard;
    rst_n      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    cpu_pc     = 32'd0;
    #2 rst_n   = 1'b0;
    #1;
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_cycles", 32'(run_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic load and stop on PC limit
    load_prog(1'b0, "basic");
    cpu_pc = 32'h0040_0000;
    @(negedge clk);
    cpu_pc = 32'h0040_0004;
    @(negedge clk);
    check("pc_not_done_yet", 32'(done), 32'd0);
    cpu_pc = 32'h0040_0008;
    @(negedge clk);
    check("pc_done", 32'(done), 32'd1);
    check("pc_hold", 32'(cpu_hold), 32'd1);
    check("pc_running", 32'(running), 32'd0);
    check("pc_timeout", 32'(timeout), 32'd0);
    check("pc_cycles", 32'(run_cycles), 32'd3);

    // gapped stream
    do_reset();
    cpu_pc = 32'd0;
    load_prog(1'b1, "gap");
    cpu_pc = 32'h0040_0008;
    @(negedge clk);
    check("gap_done", 32'(done), 32'd1);
    check("gap_cycles", 32'(run_cycles), 32'd1);

    // zero-length program
    do_reset();
    s = wr_n;
    cpu_pc = 32'h0040_0000;
    send_word(32'd0, 1'b0);
    send_word(32'd0, 1'b0);
    byte_valid = 1'b0;
    check("zero_running", 32'(running), 32'd1);
    check("zero_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_hold_again", 32'(cpu_hold), 32'd1);
    check("zero_timeout", 32'(timeout), 32'd0);
    check("zero_cycles", 32'(run_cycles), 32'd1);
    check("zero_nwrites", 32'(wr_n - s), 32'd0);

    // timeout with cycle budget 10
    do_reset();
    s = wr_n;
    cpu_pc = 32'h0040_0000;
    send_word(32'd0, 1'b0);
    send_word(32'h0040_0100, 1'b0);
    byte_valid = 1'b0;
    check("to_running", 32'(running), 32'd1);
    guard = 0;
    while (!done && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("to_done", 32'(done), 32'd1);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_cycles", 32'(run_cycles), 32'd10);
    check("to_hold", 32'(cpu_hold), 32'd1);
    byte_valid = 1'b1;
    byte_in    = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("to_ready_low", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    check("to_sticky_done", 32'(done), 32'd1);
    check("to_cycles_frozen", 32'(run_cycles), 32'd10);
    check("to_nwrites", 32'(wr_n - s), 32'd0);

    // async reset between bytes 2 and 3 of the second program word
    do_reset();
    cpu_pc = 32'd0;
    send_word(32'd2, 1'b0);
    send_word(32'h0040_0008, 1'b0);
    send_word(W0, 1'b0);
    put_byte(W1[31:24], 1'b0);
    put_byte(W1[23:16], 1'b0);
    byte_valid = 1'b0;
    check("ar_wdata_before", mem_wdata, W0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_hold", 32'(cpu_hold), 32'd1);
    check("ar_we", 32'(mem_we), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_wdata", mem_wdata, 32'd0);
    check("ar_addr", mem_addr, BASE);
    check("ar_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    load_prog(1'b0, "ar");
    cpu_pc = 32'h0040_0010;
    @(negedge clk);
    check("ar_run_done", 32'(done), 32'd1);
    check("ar_run_timeout", 32'(timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got stuck expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
